// File: rtl/n64_cmd_serializer_if.sv
// Handshake/bit-stream bundle between a command requester and the N64 command
// serializer. The master issues Start/Cmd_In; the slave drives the bit stream
// and status.
interface n64_cmd_serializer_if #(
    parameter int CMD_BITS = 8
);
    logic                Start;
    logic [CMD_BITS-1:0] Cmd_In;
    logic                Data_Out;
    logic                Enable;
    logic                Busy;
    logic                Done;
    logic                Rx_Start;

    modport master (
        output Start,
        output Cmd_In,
        input  Data_Out,
        input  Enable,
        input  Busy,
        input  Done,
        input  Rx_Start
    );

    modport slave (
        input  Start,
        input  Cmd_In,
        output Data_Out,
        output Enable,
        output Busy,
        output Done,
        output Rx_Start
    );
endinterface

// File: rtl/n64_cmd_serializer.sv
// N64 controller-link command serializer: captures a command word on Start,
// sends it MSB-first as 4-clock bit slots, then a stop bit (1), then pulses
// Done/Rx_Start for one clock to hand the line to the response receiver.
module n64_cmd_serializer #(
    parameter int CMD_BITS  = 8,
    parameter int SLOT_CLKS = 4
) (
    input  logic                    clk,
    input  logic                    Reset,
    n64_cmd_serializer_if.slave     bus
);
    localparam int         BCW   = $clog2(CMD_BITS + 1);
    localparam logic [1:0] QLAST = 2'(SLOT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        FINISH
    } state_t;

    state_t              state;
    logic [CMD_BITS-1:0] shreg;
    logic [CMD_BITS-1:0] shreg_next;
    logic [BCW-1:0]      bitcnt;
    logic [1:0]          qcnt;

    logic                data_q;
    logic                enable_q;
    logic                busy_q;
    logic                done_q;

    // Next shift-register contents once the current MSB has been sent.
    always_comb begin
        shreg_next = shreg << 1;
    end

    // Transaction sequencer. Outputs are registered and loaded with the value
    // the next state will present, so they line up with the state transition.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            qcnt     <= '0;
            data_q   <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        shreg    <= bus.Cmd_In;
                        bitcnt   <= BCW'(CMD_BITS - 1);
                        qcnt     <= '0;
                        state    <= DATA;
                        busy_q   <= 1'b1;
                        enable_q <= 1'b1;
                        data_q   <= bus.Cmd_In[CMD_BITS-1];
                    end
                end
                DATA: begin
                    qcnt <= qcnt + 2'd1;
                    if (qcnt == QLAST) begin
                        if (bitcnt == '0) begin
                            qcnt   <= '0;
                            state  <= STOP;
                            data_q <= 1'b1;
                        end else begin
                            shreg  <= shreg_next;
                            bitcnt <= bitcnt - 1'b1;
                            data_q <= shreg_next[CMD_BITS-1];
                        end
                    end
                end
                STOP: begin
                    qcnt <= qcnt + 2'd1;
                    if (qcnt == QLAST) begin
                        qcnt     <= '0;
                        state    <= FINISH;
                        enable_q <= 1'b0;
                        data_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Data_Out = data_q;
    assign bus.Enable   = enable_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Rx_Start = done_q;
endmodule

// File: tb/tb_n64_cmd_serializer.sv
// Testbench for n64_cmd_serializer: an 8-bit and a 1-bit instance are compared
// cycle by cycle against a waveform model derived from the slot timing rules.
module tb_n64_cmd_serializer;
    logic clk;
    logic Reset;
    int   total;
    int   bad;

    n64_cmd_serializer_if #(.CMD_BITS(8)) bus8 ();
    n64_cmd_serializer_if #(.CMD_BITS(1)) bus1 ();

    n64_cmd_serializer #(.CMD_BITS(8), .SLOT_CLKS(4)) dut8 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus8)
    );

    n64_cmd_serializer #(.CMD_BITS(1), .SLOT_CLKS(4)) dut1 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {Data_Out, Enable, Busy, Done, Rx_Start} on clock k+t, where
    // Start was accepted at edge k and n command bits are sent.
    function automatic logic [4:0] ref_out(input logic [31:0] cmd, input int n, input int t);
        logic [4:0] r;
        r = 5'b00000;
        if (t >= 1 && t <= 4 * n)
            r = {cmd[n - 1 - (t - 1) / 4], 4'b1100};
        else if (t > 4 * n && t <= 4 * n + 4)
            r = 5'b11100;
        else if (t == 4 * n + 5)
            r = 5'b00111;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept8(input logic [7:0] c);
        bus8.Cmd_In = c;
        bus8.Start  = 1'b1;
        tick();
        bus8.Start  = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] g8;
        logic [4:0] g1;
        Reset = 1'b0;
        bus8.Start = 1'b1; bus8.Cmd_In = 8'hFF;
        bus1.Start = 1'b1; bus1.Cmd_In = 1'b1;
        tick(); tick();
        g8 = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
        g1 = {bus1.Data_Out, bus1.Enable, bus1.Busy, bus1.Done, bus1.Rx_Start};
        total++;
        if (g8 !== 5'b00000) begin
            bad++; $display("FAIL reset8 got=%b exp=%b", g8, 5'b00000);
        end
        total++;
        if (g1 !== 5'b00000) begin
            bad++; $display("FAIL reset1 got=%b exp=%b", g1, 5'b00000);
        end
        bus8.Start = 1'b0; bus1.Start = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        tick();
        g8 = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
        total++;
        if (g8 !== 5'b00000) begin
            bad++; $display("FAIL idle_after_reset got=%b exp=%b", g8, 5'b00000);
        end
    endtask

    task automatic test_fixed(input string name, input logic [7:0] c);
        logic [4:0] g;
        logic [4:0] e;
        accept8(c);
        for (int t = 1; t <= 38; t++) begin
            g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
            e = ref_out({24'd0, c}, 8, t);
            total++;
            if (g !== e) begin
                bad++; $display("FAIL %s t=%0d got=%b exp=%b", name, t, g, e);
            end
            tick();
        end
    endtask

    task automatic test_cmd_change();
        logic [4:0] g;
        logic [4:0] e;
        accept8(8'hA5);
        for (int t = 1; t <= 38; t++) begin
            g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
            e = ref_out(32'hA5, 8, t);
            total++;
            if (g !== e) begin
                bad++; $display("FAIL cmd_change t=%0d got=%b exp=%b", t, g, e);
            end
            if (t == 5) bus8.Cmd_In = 8'h00;
            tick();
        end
    endtask

    task automatic test_ignored_start();
        logic [4:0] g;
        logic [4:0] e;
        logic [7:0] c1;
        logic [7:0] c2;
        int         dones;
        c1 = 8'($urandom);
        c2 = 8'($urandom);
        dones = 0;
        accept8(c1);
        for (int t = 1; t <= 38; t++) begin
            g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
            e = ref_out({24'd0, c1}, 8, t);
            total++;
            if (g !== e) begin
                bad++; $display("FAIL ignored_start t=%0d got=%b exp=%b", t, g, e);
            end
            if (bus8.Done === 1'b1) dones++;
            bus8.Start  = (t == 10 || t == 34 || t == 37 || t == 38);
            bus8.Cmd_In = (t == 38) ? c2 : 8'($urandom);
            tick();
        end
        bus8.Start = 1'b0;
        total++;
        if (dones !== 1) begin
            bad++; $display("FAIL done_count got=%0d exp=%0d", dones, 1);
        end
        for (int t = 1; t <= 38; t++) begin
            g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
            e = ref_out({24'd0, c2}, 8, t);
            total++;
            if (g !== e) begin
                bad++; $display("FAIL start_at_idle t=%0d got=%b exp=%b", t, g, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] g;
        logic [4:0] e;
        accept8(8'hFF);
        for (int t = 1; t <= 15; t++) begin
            g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
            e = ref_out(32'hFF, 8, t);
            total++;
            if (g !== e) begin
                bad++; $display("FAIL pre_reset t=%0d got=%b exp=%b", t, g, e);
            end
            if (t < 15) tick();
        end
        Reset = 1'b0;
        #1;
        g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
        total++;
        if (g !== 5'b00000) begin
            bad++; $display("FAIL async_reset got=%b exp=%b", g, 5'b00000);
        end
        tick(); tick();
        @(negedge clk);
        Reset = 1'b1;
        for (int t = 0; t < 30; t++) begin
            tick();
            g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
            total++;
            if (g !== 5'b00000) begin
                bad++; $display("FAIL post_reset_idle t=%0d got=%b exp=%b", t, g, 5'b00000);
            end
        end
        accept8(8'h03);
        for (int t = 1; t <= 38; t++) begin
            g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
            e = ref_out(32'h03, 8, t);
            total++;
            if (g !== e) begin
                bad++; $display("FAIL after_reset_txn t=%0d got=%b exp=%b", t, g, e);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [4:0] g;
        logic [4:0] e;
        logic [7:0] c;
        int         gap;
        for (int n = 0; n < 20; n++) begin
            c = 8'($urandom);
            accept8(c);
            for (int t = 1; t <= 38; t++) begin
                g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
                e = ref_out({24'd0, c}, 8, t);
                total++;
                if (g !== e) begin
                    bad++; $display("FAIL random n=%0d cmd=%h t=%0d got=%b exp=%b", n, c, t, g, e);
                end
                bus8.Cmd_In = 8'($urandom);
                bus8.Start  = (t <= 37) ? 1'($urandom) : 1'b0;
                tick();
            end
            gap = int'($urandom_range(0, 3));
            for (int i = 0; i < gap; i++) begin
                g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
                total++;
                if (g !== 5'b00000) begin
                    bad++; $display("FAIL random_gap n=%0d got=%b exp=%b", n, g, 5'b00000);
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] g;
        logic [4:0] e;
        logic [7:0] cur;
        logic [7:0] nxt;
        cur = 8'($urandom);
        nxt = cur;
        bus8.Cmd_In = cur;
        bus8.Start  = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            for (int t = 1; t <= 38; t++) begin
                g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
                e = ref_out({24'd0, cur}, 8, t);
                total++;
                if (g !== e) begin
                    bad++; $display("FAIL back_to_back p=%0d t=%0d got=%b exp=%b", p, t, g, e);
                end
                if (t == 20) begin
                    nxt = 8'($urandom);
                    bus8.Cmd_In = nxt;
                end
                if (t == 38 && p == 2) bus8.Start = 1'b0;
                tick();
            end
            cur = nxt;
        end
        g = {bus8.Data_Out, bus8.Enable, bus8.Busy, bus8.Done, bus8.Rx_Start};
        total++;
        if (g !== 5'b00000) begin
            bad++; $display("FAIL back_to_back_end got=%b exp=%b", g, 5'b00000);
        end
    endtask

    task automatic test_one_bit();
        logic [4:0] g;
        logic [4:0] e;
        logic       c;
        for (int n = 0; n < 2; n++) begin
            c = 1'(n);
            bus1.Cmd_In = c;
            bus1.Start  = 1'b1;
            tick();
            bus1.Start  = 1'b0;
            for (int t = 1; t <= 10; t++) begin
                g = {bus1.Data_Out, bus1.Enable, bus1.Busy, bus1.Done, bus1.Rx_Start};
                e = ref_out({31'd0, c}, 1, t);
                total++;
                if (g !== e) begin
                    bad++; $display("FAIL one_bit cmd=%b t=%0d got=%b exp=%b", c, t, g, e);
                end
                tick();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b0;
        bus8.Start = 1'b0; bus8.Cmd_In = '0;
        bus1.Start = 1'b0; bus1.Cmd_In = '0;
        test_reset();
        test_fixed("cmd01", 8'h01);
        test_fixed("cmd00", 8'h00);
        test_cmd_change();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_one_bit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
